// File: rtl/alarm_kontrol.sv
// Smoke alarm controller: debounces the sensor level code and drives siren, lamp and
// a latched alarm flag through a NORMAL/UYARI/ALARM/SUSTUR state machine.
module alarm_kontrol #(
   parameter int FILTRE_CEVRIM    = 4,
   parameter int YANIP_SONME_YARI = 8,
   parameter int SUSTURMA_CEVRIM  = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] seviye,
   input  logic       onay,
   output logic [1:0] durum,
   output logic       siren,
   output logic       lamba,
   output logic       alarm_kilit
);

   typedef enum logic [1:0] {
      NORMAL = 2'b00,
      UYARI  = 2'b01,
      ALARM  = 2'b10,
      SUSTUR = 2'b11
   } durum_t;

   localparam int FW = $clog2(FILTRE_CEVRIM + 1);
   localparam int BW = (YANIP_SONME_YARI > 1) ? $clog2(YANIP_SONME_YARI) : 1;
   localparam int SW = (SUSTURMA_CEVRIM > 1) ? $clog2(SUSTURMA_CEVRIM) : 1;

   localparam logic [FW-1:0] FILTRE_SON = FW'(FILTRE_CEVRIM);
   localparam logic [BW-1:0] YANIP_SON  = BW'(YANIP_SONME_YARI - 1);
   localparam logic [SW-1:0] SUSTUR_SON = SW'(SUSTURMA_CEVRIM - 1);

   logic [1:0]    r_seviyeF;
   logic [1:0]    r_oncekiOrnek;
   logic [FW-1:0] r_filtreSay;
   logic [FW-1:0] w_yeniSay;

   durum_t        r_durum;
   durum_t        w_sonraki;
   logic          w_giris;
   logic [SW-1:0] r_susturSay;
   logic [BW-1:0] r_yanipSay;
   logic          r_faz;
   logic          r_kilit;

   // A run only continues while the count is live and the sample repeats the previous one.
   assign w_yeniSay = ((r_filtreSay != '0) && (seviye == r_oncekiOrnek))
                      ? r_filtreSay + FW'(1) : FW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seviyeF     <= 2'b00;
         r_oncekiOrnek <= 2'b00;
         r_filtreSay   <= '0;
      end else begin
         r_oncekiOrnek <= seviye;
         if (seviye == r_seviyeF) begin
            r_filtreSay <= '0;
         end else if (w_yeniSay == FILTRE_SON) begin
            r_seviyeF   <= seviye;
            r_filtreSay <= '0;
         end else begin
            r_filtreSay <= w_yeniSay;
         end
      end
   end

   // ALARM is sticky; SUSTUR checks critical smoke every cycle, other levels only at expiry.
   always_comb begin
      w_sonraki = r_durum;
      case (r_durum)
         NORMAL: begin
            if (r_seviyeF == 2'b01)     w_sonraki = UYARI;
            else if (r_seviyeF[1])      w_sonraki = ALARM;
         end
         UYARI: begin
            if (r_seviyeF == 2'b00)     w_sonraki = NORMAL;
            else if (r_seviyeF[1])      w_sonraki = ALARM;
         end
         ALARM: begin
            if (onay && (r_seviyeF != 2'b11)) w_sonraki = SUSTUR;
         end
         SUSTUR: begin
            if (r_seviyeF == 2'b11) begin
               w_sonraki = ALARM;
            end else if (r_susturSay == '0) begin
               if (r_seviyeF[1])              w_sonraki = ALARM;
               else if (r_seviyeF == 2'b01)   w_sonraki = UYARI;
               else                           w_sonraki = NORMAL;
            end
         end
         default: w_sonraki = NORMAL;
      endcase
   end

   assign w_giris = (w_sonraki != r_durum);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_durum     <= NORMAL;
         r_susturSay <= '0;
         r_yanipSay  <= '0;
         r_faz       <= 1'b0;
         r_kilit     <= 1'b0;
      end else begin
         r_durum <= w_sonraki;
         if (w_giris) begin
            r_yanipSay <= '0;
            r_faz      <= 1'b1;
         end else if (r_yanipSay == YANIP_SON) begin
            r_yanipSay <= '0;
            r_faz      <= ~r_faz;
         end else begin
            r_yanipSay <= r_yanipSay + BW'(1);
         end
         if (w_giris && (w_sonraki == SUSTUR)) begin
            r_susturSay <= SUSTUR_SON;
         end else if (r_susturSay != '0) begin
            r_susturSay <= r_susturSay - SW'(1);
         end
         if (w_giris && (w_sonraki == ALARM)) begin
            r_kilit <= 1'b1;
         end else if (w_giris && (w_sonraki == NORMAL)) begin
            r_kilit <= 1'b0;
         end
      end
   end

   assign durum       = r_durum;
   assign siren       = (r_durum == ALARM);
   assign alarm_kilit = r_kilit;

   always_comb begin
      lamba = 1'b0;
      case (r_durum)
         ALARM:         lamba = 1'b1;
         UYARI, SUSTUR: lamba = r_faz;
         default:       lamba = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alarm_kontrol.sv
// Bench for alarm_kontrol: directed vector table, hand-written timing sequences and
// randomized traffic compared against an arithmetic reference model.
module tb_alarm_kontrol;

   localparam int F = 4;
   localparam int Y = 8;
   localparam int S = 32;

   logic       clk;
   logic       rst;
   logic [1:0] seviye;
   logic       onay;
   logic [1:0] durum;
   logic       siren;
   logic       lamba;
   logic       alarm_kilit;

   alarm_kontrol #(
      .FILTRE_CEVRIM   (F),
      .YANIP_SONME_YARI(Y),
      .SUSTURMA_CEVRIM (S)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seviye     (seviye),
      .onay       (onay),
      .durum      (durum),
      .siren      (siren),
      .lamba      (lamba),
      .alarm_kilit(alarm_kilit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int nChecks = 0;
   int nPass   = 0;

   // Reference model: state number, edges since state entry, filtered level, latch flag,
   // and the raw history of samples since the last reset.
   int         mState = 0;
   int         mT     = 0;
   int         mF     = 0;
   int         mKilit = 0;
   logic [1:0] hist[$];

   function automatic logic [4:0] modelOut();
      logic l;
      l = 1'b0;
      if (mState == 2) l = 1'b1;
      else if (mState == 1 || mState == 3) l = (((mT / Y) % 2) == 0);
      return {2'(mState), (mState == 2), l, (mKilit != 0)};
   endfunction

   task automatic modelStep(input logic r, input logic [1:0] s, input logic o);
      int nxt;
      bit allSame;
      if (r) begin
         mState = 0; mT = 0; mF = 0; mKilit = 0;
         hist.delete();
         return;
      end
      nxt = mState;
      case (mState)
         0: if (mF == 1) nxt = 1; else if (mF >= 2) nxt = 2;
         1: if (mF == 0) nxt = 0; else if (mF >= 2) nxt = 2;
         2: if (o && mF != 3) nxt = 3;
         default: begin
            if (mF == 3) nxt = 2;
            else if (mT == S - 1) nxt = (mF >= 2) ? 2 : mF;
         end
      endcase
      hist.push_back(s);
      if (hist.size() > F) void'(hist.pop_front());
      if (hist.size() == F) begin
         allSame = 1'b1;
         foreach (hist[i]) if (hist[i] != hist[0]) allSame = 1'b0;
         if (allSame && int'(hist[0]) != mF) mF = int'(hist[0]);
      end
      if (nxt != mState) begin
         mT = 0;
         if (nxt == 2) mKilit = 1;
         if (nxt == 0) mKilit = 0;
      end else begin
         mT++;
      end
      mState = nxt;
   endtask

   task automatic applyStimulus(input logic r, input logic [1:0] s, input logic o);
      rst    = r;
      seviye = s;
      onay   = o;
      @(posedge clk);
      modelStep(r, s, o);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [4:0] expv);
      logic [4:0] act;
      act = {durum, siren, lamba, alarm_kilit};
      nChecks++;
      if (act === expv) nPass++;
      else $display("[TB] FAIL %s: got {durum,siren,lamba,kilit}=%b, want %b", name, act, expv);
   endtask

   typedef struct {
      logic       r;
      logic [1:0] s;
      logic       o;
      int         cyc;
      logic [4:0] expv;
      string      name;
   } vec_t;

   vec_t vecs[25];

   initial begin
      rst = 1'b1; seviye = 2'b00; onay = 1'b0;

      vecs[0]  = '{1'b1, 2'b11, 1'b1, 2,   5'b00000, "reset"};
      vecs[1]  = '{1'b0, 2'b11, 1'b1, 4,   5'b00000, "latency4"};
      vecs[2]  = '{1'b0, 2'b11, 1'b1, 1,   5'b10111, "alarmEdge5"};
      vecs[3]  = '{1'b0, 2'b11, 1'b1, 5,   5'b10111, "critOnayIgnored"};
      vecs[4]  = '{1'b0, 2'b00, 1'b0, 100, 5'b10111, "alarmLatched"};
      vecs[5]  = '{1'b0, 2'b00, 1'b1, 1,   5'b11011, "ackToSustur"};
      vecs[6]  = '{1'b0, 2'b00, 1'b0, 31,  5'b11001, "susturLastCycle"};
      vecs[7]  = '{1'b0, 2'b00, 1'b0, 1,   5'b00000, "susturExpireNormal"};
      vecs[8]  = '{1'b0, 2'b10, 1'b0, 3,   5'b00000, "glitchHeld"};
      vecs[9]  = '{1'b0, 2'b00, 1'b0, 10,  5'b00000, "glitchRejected"};
      vecs[10] = '{1'b0, 2'b01, 1'b0, 4,   5'b00000, "uyariLatency4"};
      vecs[11] = '{1'b0, 2'b01, 1'b0, 1,   5'b01010, "uyariEnter"};
      vecs[12] = '{1'b0, 2'b01, 1'b0, 7,   5'b01010, "blinkOnEnd"};
      vecs[13] = '{1'b0, 2'b01, 1'b0, 1,   5'b01000, "blinkOff"};
      vecs[14] = '{1'b0, 2'b01, 1'b0, 8,   5'b01010, "blinkOnAgain"};
      vecs[15] = '{1'b0, 2'b10, 1'b0, 4,   5'b01010, "uyariHeavyFilter"};
      vecs[16] = '{1'b0, 2'b10, 1'b0, 1,   5'b10111, "uyariToAlarm"};
      vecs[17] = '{1'b0, 2'b10, 1'b1, 1,   5'b11011, "heavyAck"};
      vecs[18] = '{1'b0, 2'b11, 1'b0, 4,   5'b11011, "susturCritFilter"};
      vecs[19] = '{1'b0, 2'b11, 1'b0, 1,   5'b10111, "susturCritReAlarm"};
      vecs[20] = '{1'b0, 2'b01, 1'b1, 1,   5'b10111, "ackWhileStillCrit"};
      vecs[21] = '{1'b0, 2'b01, 1'b0, 3,   5'b10111, "alarmLightFilter"};
      vecs[22] = '{1'b0, 2'b01, 1'b1, 1,   5'b11011, "lightAck"};
      vecs[23] = '{1'b0, 2'b01, 1'b0, 10,  5'b11001, "susturBlinkOff"};
      vecs[24] = '{1'b1, 2'b01, 1'b0, 1,   5'b00000, "rstMidSustur"};

      for (int v = 0; v < 25; v++) begin
         for (int c = 0; c < vecs[v].cyc; c++) applyStimulus(vecs[v].r, vecs[v].s, vecs[v].o);
         checkOutput(vecs[v].name, vecs[v].expv);
      end

      // Filter restart: a different value mid-run must start the count over.
      applyStimulus(1'b1, 2'b00, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 2'b10, 1'b0);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 2'b11, 1'b0);
      checkOutput("filterRestartWait", 5'b00000);
      applyStimulus(1'b0, 2'b11, 1'b0);
      checkOutput("filterRestartAlarm", 5'b10111);

      // Blink cadence in UYARI: 8 on, 8 off, 8 on from the entry cycle.
      applyStimulus(1'b1, 2'b00, 1'b0);
      for (int c = 0; c < 5; c++) applyStimulus(1'b0, 2'b01, 1'b0);
      for (int i = 0; i < 24; i++) begin
         checkOutput($sformatf("blink%0d", i), {2'b01, 1'b0, (((i / 8) % 2) == 0), 1'b0});
         applyStimulus(1'b0, 2'b01, 1'b0);
      end

      // Randomized traffic with sticky levels so the filter and silence window get exercised.
      applyStimulus(1'b1, 2'b00, 1'b0);
      begin
         logic [1:0] lvl;
         logic       r, o;
         lvl = 2'b00;
         for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 11) == 0) lvl = 2'($urandom_range(0, 3));
            o = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 499) == 0);
            applyStimulus(r, lvl, o);
            checkOutput($sformatf("random%0d", n), modelOut());
         end
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
